// File: rtl/multi_input_gate_checker.sv
// Exhaustive gate-IC checker: steps all 2^N_INPUTS patterns onto N_CH parallel
// gate channels and compares each channel output with a selectable reference gate.
module multi_input_gate_checker #(
    parameter int N_INPUTS      = 4,
    parameter int N_CH          = 2,
    parameter int SETTLE_CYCLES = 50000000,
    parameter int CNT_W         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [2:0]          gate_sel,
    input  logic [N_CH-1:0]     op,
    output logic [N_INPUTS-1:0] stim,
    output logic                busy,
    output logic                done,
    output logic [N_CH-1:0]     pass_ch,
    output logic [N_CH-1:0]     fail_ch,
    output logic                pass,
    output logic                fail,
    output logic                cfg_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] PAT_LAST = '1;

    logic [1:0]      state;
    logic [2:0]      sel_q;
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0] mismatch;

    logic            ref_bit;
    logic            sel_legal;
    logic            sample;
    logic [N_CH-1:0] mismatch_next;

    function automatic logic ref_fn(input logic [2:0] sel, input logic [N_INPUTS-1:0] p);
        case (sel)
            3'b000:  ref_fn = &p;
            3'b001:  ref_fn = ~&p;
            3'b010:  ref_fn = |p;
            3'b011:  ref_fn = ~|p;
            3'b100:  ref_fn = ^p;
            3'b101:  ref_fn = ~^p;
            default: ref_fn = 1'b0;
        endcase
    endfunction

    assign ref_bit   = ref_fn(sel_q, stim);
    assign sel_legal = (gate_sel[2:1] != 2'b11);
    assign sample    = (cnt == CNT_LAST);
    // Folding the current sample in here lets the final pattern reach the verdict.
    assign mismatch_next = mismatch | (op ^ {N_CH{ref_bit}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sel_q    <= 3'b000;
            cnt      <= '0;
            mismatch <= '0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_ch  <= '0;
            fail_ch  <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        if (sel_legal) begin
                            sel_q    <= gate_sel;
                            stim     <= '0;
                            cnt      <= '0;
                            mismatch <= '0;
                            busy     <= 1'b1;
                            state    <= S_DRIVE;
                        end else begin
                            cfg_err <= 1'b1;
                            state   <= S_ERR;
                        end
                    end
                end
                S_DRIVE: begin
                    if (!enable) begin
                        stim     <= '0;
                        cnt      <= '0;
                        mismatch <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (sample) begin
                        mismatch <= mismatch_next;
                        cnt      <= '0;
                        if (stim == PAT_LAST) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            stim    <= '0;
                            pass_ch <= ~mismatch_next;
                            fail_ch <= mismatch_next;
                            pass    <= (mismatch_next == '0);
                            fail    <= |mismatch_next;
                            state   <= S_DONE;
                        end else begin
                            stim <= stim + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        done     <= 1'b0;
                        pass_ch  <= '0;
                        fail_ch  <= '0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        mismatch <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    if (!enable) begin
                        cfg_err <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_input_gate_checker.sv
// Bench for multi_input_gate_checker: two instances (4-in/2-ch and 3-in/4-ch)
// driven by behavioural gate models, verdicts predicted by enumerating all patterns.
module tb_multi_input_gate_checker;

    localparam int SETTLE = 4;

    logic       clk;
    logic       rst_n;
    logic       en_a, en_b;
    logic [2:0] sel_a, sel_b;
    logic [1:0] op_a, pass_ch_a, fail_ch_a;
    logic [3:0] op_b, pass_ch_b, fail_ch_b;
    logic [3:0] stim_a;
    logic [2:0] stim_b;
    logic       busy_a, done_a, pass_a, fail_a, cfg_err_a;
    logic       busy_b, done_b, pass_b, fail_b, cfg_err_b;

    int  checks = 0;
    int  errors = 0;
    int  cur = 0;
    int  chan_gate [2][8];
    bit  flip_en   [2][8];
    int  flip_pat  [2][8];

    logic [5:0] obs_stim;
    logic [7:0] obs_pass_ch, obs_fail_ch;
    logic       obs_busy, obs_done, obs_pass, obs_fail, obs_cfg;

    multi_input_gate_checker #(.N_INPUTS(4), .N_CH(2), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .gate_sel(sel_a), .op(op_a), .stim(stim_a),
        .busy(busy_a), .done(done_a), .pass_ch(pass_ch_a), .fail_ch(fail_ch_a),
        .pass(pass_a), .fail(fail_a), .cfg_err(cfg_err_a));

    multi_input_gate_checker #(.N_INPUTS(3), .N_CH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .gate_sel(sel_b), .op(op_b), .stim(stim_b),
        .busy(busy_b), .done(done_b), .pass_ch(pass_ch_b), .fail_ch(fail_ch_b),
        .pass(pass_b), .fail(fail_b), .cfg_err(cfg_err_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gate truth from the count of ones in the pattern.
    function automatic logic gate_ref(input int sel, input int p, input int n);
        int ones;
        ones = $countones(p & ((1 << n) - 1));
        case (sel)
            0:       return ones == n;
            1:       return ones != n;
            2:       return ones != 0;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_out(input int gate, input bit fe, input int fp, input int p, input int n);
        return gate_ref(gate, p, n) ^ (fe && (p == fp));
    endfunction

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int c = 0; c < 2; c++)
            op_a[c] = model_out(chan_gate[0][c], flip_en[0][c], flip_pat[0][c], int'(stim_a), 4);
        for (int c = 0; c < 4; c++)
            op_b[c] = model_out(chan_gate[1][c], flip_en[1][c], flip_pat[1][c], int'(stim_b), 3);
    end

    always_comb begin
        if (cur == 0) begin
            obs_stim = 6'(stim_a); obs_pass_ch = 8'(pass_ch_a); obs_fail_ch = 8'(fail_ch_a);
            obs_busy = busy_a; obs_done = done_a; obs_pass = pass_a; obs_fail = fail_a; obs_cfg = cfg_err_a;
        end else begin
            obs_stim = 6'(stim_b); obs_pass_ch = 8'(pass_ch_b); obs_fail_ch = 8'(fail_ch_b);
            obs_busy = busy_b; obs_done = done_b; obs_pass = pass_b; obs_fail = fail_b; obs_cfg = cfg_err_b;
        end
    end

    function automatic int n_in();
        return (cur == 0) ? 4 : 3;
    endfunction

    function automatic int n_ch();
        return (cur == 0) ? 2 : 4;
    endfunction

    // Expected per-channel fail: any pattern where the channel model disagrees with the reference.
    function automatic logic [7:0] exp_fail(input int sel);
        logic [7:0] f;
        f = '0;
        for (int c = 0; c < n_ch(); c++)
            for (int p = 0; p < (1 << n_in()); p++)
                if (model_out(chan_gate[cur][c], flip_en[cur][c], flip_pat[cur][c], p, n_in()) != gate_ref(sel, p, n_in()))
                    f[c] = 1'b1;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input int v);
        cur = v;
        #1;
    endtask

    task automatic set_en(input logic v);
        if (cur == 0) en_a = v; else en_b = v;
    endtask

    task automatic set_sel(input int v);
        if (cur == 0) sel_a = 3'(v); else sel_b = 3'(v);
    endtask

    task automatic set_models(input int g);
        for (int c = 0; c < 8; c++) begin
            chan_gate[cur][c] = g;
            flip_en[cur][c]   = 1'b0;
            flip_pat[cur][c]  = 0;
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy_a, done_a, pass_a, fail_a, cfg_err_a, stim_a, pass_ch_a, fail_ch_a} !== '0 ||
            {busy_b, done_b, pass_b, fail_b, cfg_err_b, stim_b, pass_ch_b, fail_ch_b} !== '0) begin
            errors++;
            $display("FAIL %s: a busy=%b done=%b pass=%b fail=%b cfg=%b stim=%h pch=%b fch=%b b busy=%b done=%b pass=%b fail=%b cfg=%b stim=%h pch=%b fch=%b, required all 0",
                     name, busy_a, done_a, pass_a, fail_a, cfg_err_a, stim_a, pass_ch_a, fail_ch_a,
                     busy_b, done_b, pass_b, fail_b, cfg_err_b, stim_b, pass_ch_b, fail_ch_b);
        end
    endtask

    // Raise enable, run the full sweep, check timing, stim sequence and verdict.
    task automatic run_and_check(input int sel, input string name, input bit sel_noise, input bit keep_enable);
        logic [7:0] ef, mask;
        int total, k;
        bit stim_bad;
        int bad_k;
        logic [5:0] bad_v;
        ef    = exp_fail(sel);
        mask  = 8'((1 << n_ch()) - 1);
        total = (1 << n_in()) * SETTLE;
        set_sel(sel);
        set_en(1'b1);
        tick();
        checks++;
        if (obs_busy !== 1'b1 || obs_stim !== '0 || obs_done !== 1'b0) begin
            errors++;
            $display("FAIL %s start: busy=%b stim=%0d done=%b, required busy=1 stim=0 done=0", name, obs_busy, obs_stim, obs_done);
        end
        if (sel_noise) set_sel($urandom_range(0, 7));
        stim_bad = 0;
        bad_k = 0;
        bad_v = '0;
        for (k = 1; k <= total + 8; k++) begin
            tick();
            if (obs_done) break;
            if (!stim_bad && obs_stim !== 6'(k / SETTLE)) begin
                stim_bad = 1;
                bad_k = k;
                bad_v = obs_stim;
            end
        end
        checks++;
        if (k != total) begin
            errors++;
            $display("FAIL %s done_latency: done after %0d cycles, required %0d", name, k, total);
        end
        checks++;
        if (stim_bad) begin
            errors++;
            $display("FAIL %s stim_seq: cycle %0d stim=%0d, required %0d", name, bad_k, bad_v, bad_k / SETTLE);
        end
        checks++;
        if (obs_fail_ch !== ef || obs_pass_ch !== (~ef & mask) || obs_pass !== (ef == 0) ||
            obs_fail !== (ef != 0) || obs_busy !== 1'b0 || obs_stim !== '0) begin
            errors++;
            $display("FAIL %s verdict: fail_ch=%b pass_ch=%b pass=%b fail=%b busy=%b stim=%0d, required fail_ch=%b pass_ch=%b pass=%b fail=%b busy=0 stim=0",
                     name, obs_fail_ch, obs_pass_ch, obs_pass, obs_fail, obs_busy, obs_stim,
                     ef, ~ef & mask, ef == 0, ef != 0);
        end
        set_sel($urandom_range(0, 7));
        tick();
        tick();
        checks++;
        if (obs_done !== 1'b1 || obs_fail_ch !== ef || obs_pass_ch !== (~ef & mask)) begin
            errors++;
            $display("FAIL %s hold: done=%b fail_ch=%b pass_ch=%b, required done=1 fail_ch=%b pass_ch=%b",
                     name, obs_done, obs_fail_ch, obs_pass_ch, ef, ~ef & mask);
        end
        if (!keep_enable) begin
            set_en(1'b0);
            tick();
            checks++;
            if ({obs_done, obs_pass, obs_fail, obs_pass_ch, obs_fail_ch, obs_busy} !== '0) begin
                errors++;
                $display("FAIL %s release: done=%b pass=%b fail=%b pass_ch=%b fail_ch=%b busy=%b, required all 0",
                         name, obs_done, obs_pass, obs_fail, obs_pass_ch, obs_fail_ch, obs_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_and_pass();
        set_cur(0);
        set_models(0);
        run_and_check(0, "and_pass", 0, 0);
    endtask

    task automatic test_last_pattern();
        set_cur(0);
        set_models(0);
        flip_en[0][1]  = 1'b1;
        flip_pat[0][1] = 15;
        run_and_check(0, "last_pattern", 0, 0);
    endtask

    task automatic test_xor_channels();
        set_cur(1);
        set_models(4);
        chan_gate[1][2] = 5;
        run_and_check(4, "xor_4ch", 0, 0);
    endtask

    task automatic test_cfg_err(input int inst, input int sel);
        set_cur(inst);
        set_sel(sel);
        set_en(1'b1);
        tick();
        checks++;
        if (obs_cfg !== 1'b1 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_set sel=%0d: cfg_err=%b busy=%b, required cfg_err=1 busy=0", sel, obs_cfg, obs_busy);
        end
        tick();
        checks++;
        if (obs_cfg !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_hold: cfg_err=%b busy=%b done=%b, required 1 0 0", obs_cfg, obs_busy, obs_done);
        end
        set_en(1'b0);
        tick();
        checks++;
        if (obs_cfg !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clear: cfg_err=%b, required 0", obs_cfg);
        end
    endtask

    task automatic test_abort();
        set_cur(0);
        set_models(2);
        chan_gate[0][0] = 3;
        set_sel(2);
        set_en(1'b1);
        tick();
        repeat (19) tick();
        set_en(1'b0);
        tick();
        checks++;
        if (obs_busy !== 1'b0 || obs_stim !== '0 || obs_done !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b stim=%0d done=%b, required 0 0 0", obs_busy, obs_stim, obs_done);
        end
        run_and_check(2, "after_abort", 0, 0);
    endtask

    task automatic test_reset_in_run();
        set_cur(0);
        set_models(1);
        set_sel(1);
        set_en(1'b1);
        tick();
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("reset_in_drive");
        rst_n = 1'b1;
        run_and_check(1, "after_drive_reset", 0, 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("reset_in_done");
        rst_n = 1'b1;
        set_models(5);
        run_and_check(5, "after_done_reset", 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int sel;
            set_cur($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            for (int c = 0; c < 8; c++) begin
                chan_gate[cur][c] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : sel;
                flip_en[cur][c]   = ($urandom_range(0, 3) == 0);
                flip_pat[cur][c]  = $urandom_range(0, (1 << n_in()) - 1);
            end
            run_and_check(sel, $sformatf("random_%0d", it), 1, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        sel_a = 3'b000;
        sel_b = 3'b000;
        for (int i = 0; i < 2; i++) begin
            cur = i;
            set_models(0);
        end
        cur = 0;
        test_reset();
        test_and_pass();
        test_last_pattern();
        test_xor_channels();
        test_cfg_err(0, 6);
        test_cfg_err(1, 7);
        test_abort();
        test_reset_in_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
